// File: rtl/pea_pkg.sv
// Shared PEA types: the legacy single-shot sequencer states plus the
// execution controller's state and run-termination encodings.
package pea_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    IDLE_X,
    EXEC_X,
    DRAIN_X,
    DONE_X
  } exec_state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ABORT   = 2'd1,
    ST_TIMEOUT = 2'd2
  } exec_status_t;

endpackage

// File: rtl/mage_exec_ctrl_watchdog.sv
// EXEC-phase watchdog for mage_exec_ctrl; only built when MAGE_EXEC_WATCHDOG_EN
// is defined, so the default build carries no watchdog module at all.
`ifdef MAGE_EXEC_WATCHDOG_EN
module mage_exec_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Counts up while enabled and parks at all-ones until cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = &cnt_q;

endmodule
`endif

// File: rtl/mage_exec_ctrl.sv
// Iterating execution controller for the PEA: IDLE -> EXEC -> DRAIN -> DONE with
// abort, sticky interrupt and an optional watchdog (macro MAGE_EXEC_WATCHDOG_EN).
module mage_exec_ctrl
  import pea_pkg::*;
#(
  parameter int ITER_W       = 16,
  parameter int DRAIN_CYCLES = 4
`ifdef MAGE_EXEC_WATCHDOG_EN
  ,
  parameter int TIMEOUT_W    = 20
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ITER_W-1:0] n_iter_i,
  input  logic              iter_end_i,
  input  logic              abort_i,
  input  logic              intr_ack_i,
  output exec_state_t       state_o,
  output logic              busy_o,
  output logic              intr_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output exec_status_t      status_o
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [ITER_W-1:0]  ITER_MAX   = '1;

  exec_state_t       state_q, state_d;
  exec_status_t      status_q;
  logic [ITER_W-1:0] n_iter_q;
  logic [ITER_W-1:0] iter_cnt_q;
  logic [ITER_W-1:0] iter_cnt_inc;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic              last_iter;
  logic              wd_expired;

  assign iter_cnt_inc = (iter_cnt_q == ITER_MAX) ? iter_cnt_q : iter_cnt_q + 1'b1;
  assign last_iter    = iter_end_i && (iter_cnt_inc == n_iter_q);

`ifdef MAGE_EXEC_WATCHDOG_EN
  // Held clear outside EXEC, so every EXEC entry starts from zero.
  mage_exec_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  ((state_q != EXEC_X) || iter_end_i),
    .enable (state_q == EXEC_X),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE_X;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_X:  if (start_i) state_d = (n_iter_i == '0) ? DONE_X : EXEC_X;
      EXEC_X: begin
        if (abort_i || last_iter || (wd_expired && !iter_end_i)) begin
          state_d = DRAIN_X;
        end
      end
      DRAIN_X: if (drain_cnt_q == '0) state_d = DONE_X;
      DONE_X:  if (intr_ack_i) state_d = IDLE_X;
      default: state_d = IDLE_X;
    endcase
  end

  // Abort takes precedence over both a same-cycle iteration end and the watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_iter_q    <= '0;
      iter_cnt_q  <= '0;
      status_q    <= ST_OK;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE_X: begin
          if (start_i) begin
            n_iter_q   <= n_iter_i;
            iter_cnt_q <= '0;
            status_q   <= ST_OK;
          end
        end
        EXEC_X: begin
          drain_cnt_q <= DRAIN_LOAD;
          if (abort_i) begin
            status_q <= ST_ABORT;
          end else if (iter_end_i) begin
            iter_cnt_q <= iter_cnt_inc;
          end else if (wd_expired) begin
            status_q <= ST_TIMEOUT;
          end
        end
        DRAIN_X: begin
          if (drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_o = state_q;
    busy_o  = (state_q != IDLE_X);
    intr_o  = (state_q == DONE_X);
  end

  assign iter_cnt_o = iter_cnt_q;
  assign status_o   = status_q;

endmodule

// File: tb/tb_mage_exec_ctrl.sv
// Scoreboard bench for mage_exec_ctrl: runs push the expected completion record,
// and a monitor checks it when the interrupt rises.
module tb_mage_exec_ctrl;
  import pea_pkg::*;

  localparam int ITER_W       = 16;
  localparam int DRAIN_CYCLES = 4;
`ifdef MAGE_EXEC_WATCHDOG_EN
  localparam int TIMEOUT_W    = 4;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ITER_W-1:0] n_iter_i;
  logic              iter_end_i;
  logic              abort_i;
  logic              intr_ack_i;
  exec_state_t       state_o;
  logic              busy_o;
  logic              intr_o;
  logic [ITER_W-1:0] iter_cnt_o;
  exec_status_t      status_o;

  typedef struct {
    int iter_cnt;
    int status;
    int done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc        = 0;
  int   checkCount = 0;
  int   passCount  = 0;
  logic intr_prev  = 1'b0;

  mage_exec_ctrl #(
    .ITER_W      (ITER_W),
    .DRAIN_CYCLES(DRAIN_CYCLES)
`ifdef MAGE_EXEC_WATCHDOG_EN
    ,
    .TIMEOUT_W   (TIMEOUT_W)
`endif
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .n_iter_i  (n_iter_i),
    .iter_end_i(iter_end_i),
    .abort_i   (abort_i),
    .intr_ack_i(intr_ack_i),
    .state_o   (state_o),
    .busy_o    (busy_o),
    .intr_o    (intr_o),
    .iter_cnt_o(iter_cnt_o),
    .status_o  (status_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Every rising interrupt must match the oldest outstanding expected run.
  always @(negedge clk_i) begin
    if (intr_o && !intr_prev) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_intr", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("done_iter_cnt", int'(iter_cnt_o), mon_e.iter_cnt);
        checkOutput("done_status", int'(status_o), mon_e.status);
        checkOutput("done_cycle", cyc, mon_e.done_cyc);
      end
    end
    intr_prev <= intr_o;
  end

  task automatic applyStimulus(input logic start, input logic [ITER_W-1:0] n,
                               input logic iter_end, input logic abort, input logic ack);
    start_i    = start;
    n_iter_i   = n;
    iter_end_i = iter_end;
    abort_i    = abort;
    intr_ack_i = ack;
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    iter_end_i = 1'b0;
    abort_i    = 1'b0;
    intr_ack_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushExp(input int cnt, input exec_status_t st, input int done_cyc);
    exp_t e;
    e.iter_cnt = cnt;
    e.status   = int'(st);
    e.done_cyc = done_cyc;
    sb_q.push_back(e);
  endtask

  task automatic checkState(input string name, input exec_state_t expected);
    @(negedge clk_i);
    checkOutput(name, int'(state_o), int'(expected));
  endtask

  task automatic waitDone(input int bound);
    for (int i = 0; i < bound && !intr_o; i++) @(negedge clk_i);
    checkOutput("wait_done", int'(intr_o), 1);
  endtask

  task automatic checkResetValues(input string tag);
    @(negedge clk_i);
    checkOutput({tag, "_state"}, int'(state_o), int'(IDLE_X));
    checkOutput({tag, "_busy"}, int'(busy_o), 0);
    checkOutput({tag, "_intr"}, int'(intr_o), 0);
    checkOutput({tag, "_iter_cnt"}, int'(iter_cnt_o), 0);
    checkOutput({tag, "_status"}, int'(status_o), int'(ST_OK));
  endtask

  initial begin
    int t;
    int drops;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    n_iter_i   = '0;
    iter_end_i = 1'b0;
    abort_i    = 1'b0;
    intr_ack_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkResetValues("reset");
    rst_i = 1'b0;

    $display("[TB] normal run, 3 iterations");
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("start_state", int'(state_o), int'(EXEC_X));
    checkOutput("start_busy", int'(busy_o), 1);
    for (int p = 0; p < 3; p++) begin
      idle(4);
      if (p == 2) begin
        t = cyc;
        pushExp(3, ST_OK, t + 1 + DRAIN_CYCLES);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (p == 0) begin
        @(negedge clk_i);
        checkOutput("first_iter_cnt", int'(iter_cnt_o), 1);
      end
    end
    checkState("final_iter_drain", DRAIN_X);
    waitDone(20);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    checkOutput("ack_state", int'(state_o), int'(IDLE_X));
    checkOutput("ack_intr", int'(intr_o), 0);
    checkOutput("ack_busy", int'(busy_o), 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("idle_iter_end_hold", int'(iter_cnt_o), 3);

    $display("[TB] zero-iteration start");
    t = cyc;
    pushExp(0, ST_OK, t + 1);
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    checkState("zero_done", DONE_X);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkState("zero_ack", IDLE_X);

    $display("[TB] abort together with second iteration end");
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(3);
    t = cyc;
    pushExp(1, ST_ABORT, t + 1 + DRAIN_CYCLES);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checkState("abort_drain", DRAIN_X);
    waitDone(20);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkState("abort_ack", IDLE_X);

    $display("[TB] sticky interrupt ignores start until ack");
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    idle(2);
    t = cyc;
    pushExp(1, ST_OK, t + 1 + DRAIN_CYCLES);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    waitDone(20);
    drops = 0;
    repeat (20) begin
      applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
      if (!intr_o || state_o != DONE_X) drops++;
    end
    checkOutput("sticky_drops", drops, 0);
    applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
    checkState("ack_with_start", IDLE_X);
    idle(2);
    checkState("no_new_run", IDLE_X);
    checkOutput("no_new_run_cnt", int'(iter_cnt_o), 1);

`ifdef MAGE_EXEC_WATCHDOG_EN
    $display("[TB] watchdog timeout");
    t = cyc;
    pushExp(0, ST_TIMEOUT, t + 1 + 16 + DRAIN_CYCLES);
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    idle(15);
    checkState("wd_last_exec", EXEC_X);
    checkState("wd_drain", DRAIN_X);
    waitDone(30);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkState("wd_ack", IDLE_X);
`else
    $display("[TB] no watchdog: EXEC waits indefinitely");
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    idle(100);
    checkState("no_wd_exec", EXEC_X);
    t = cyc;
    pushExp(0, ST_ABORT, t + 1 + DRAIN_CYCLES);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    waitDone(20);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkState("no_wd_ack", IDLE_X);
`endif

    $display("[TB] reset during drain");
    applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkState("pre_reset_drain", DRAIN_X);
    idle(1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkResetValues("mid_reset");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("post_reset_iter_cnt", int'(iter_cnt_o), 0);
    idle(10);
    checkState("post_reset_idle", IDLE_X);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
